mux_arb_nxw: RTL and testbench

Parametrised successor to the team's 4:1 combinational selector: an N-channel, W-bit arbitrated multiplexer with per-channel valid/ready handshakes and one registered output stage. It sits between several producer lanes and one shared consumer, selecting one lane per cycle by forced select, fixed priority or round-robin, and reports which lane each output word came from.

---
 rtl/mux_arb_pkg.sv | 19 +
 rtl/mux_arb_nxw_rr_arbiter.sv | 66 ++++++
 rtl/mux_arb_nxw.sv | 83 ++++++++
 tb/tb_mux_arb_nxw.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the N-channel arbitrated multiplexer: mode encodings
// and a one-hot grant to lane index helper.
package mux_arb_pkg;

  localparam logic [1:0] MODE_FORCED = 2'b00;
  localparam logic [1:0] MODE_FIXED  = 2'b01;
  localparam logic [1:0] MODE_RR     = 2'b10;

  // Index of the set bit of a one-hot grant; zero when no bit is set.
  function automatic logic [31:0] grant_to_idx(input logic [63:0] grant);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (grant[i]) idx = 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_arb_nxw_rr_arbiter.sv
// Lane arbiter: forced, fixed-priority or round-robin one-hot grant, plus the
// round-robin pointer that advances past each lane served in round-robin mode.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic [CHANNELS-1:0] req,
  input  logic [1:0]          mode,
  input  logic [SEL_W-1:0]    force_sel,
  input  logic                enable,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic [SEL_W-1:0]    ptr
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  int               start;
  int               idx;
  logic             found;

  // Fixed priority is a round-robin search that always starts at lane 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    start = (mode == MODE_FIXED) ? 0 : int'(ptr_q);
    if (enable) begin
      if (mode == MODE_FORCED) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (force_sel == SEL_W'(k) && req[k]) grant[k] = 1'b1;
        end
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          idx = start + i;
          if (idx >= CHANNELS) idx = idx - CHANNELS;
          if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
          end
        end
      end
    end
  end

  assign grant_idx = SEL_W'(grant_to_idx(64'(grant)));

  // mode 2'b11 behaves as round-robin, so bit 1 alone identifies it.
  always_comb begin
    ptr_d = ptr_q;
    if (mode[1] && (|grant)) begin
      ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mux_arb_nxw.sv
// N-channel, W-bit arbitrated multiplexer with one registered output stage.
// Handshake: a word moves on valid && ready at a rising edge, on both sides.
module mux_arb_nxw
  import mux_arb_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          force_sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic                load_en;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic [SEL_W-1:0]    rr_ptr;
  logic [WIDTH-1:0]    lane_data;

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;

  // The output register can take a new word when empty or being drained.
  assign load_en = !out_valid_q || out_ready;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .clk       (clk),
    .reset_L   (reset_L),
    .req       (in_valid),
    .mode      (mode),
    .force_sel (force_sel),
    .enable    (load_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ptr       (rr_ptr)
  );

  assign in_ready  = grant;
  assign lane_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_en) begin
      out_valid_d = |grant;
      if (|grant) begin
        out_data_d = lane_data;
        out_sel_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_nxw.sv
// Bench for mux_arb_nxw: a 4-lane and a 3-lane instance checked against a
// behavioural model of the arbitration rules and directed expectations.
module tb_mux_arb_nxw;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  logic [15:0] in_data4;
  logic [3:0]  in_valid4, in_ready4;
  logic [1:0]  mode4, fsel4, out_sel4;
  logic [3:0]  out_data4;
  logic        out_valid4, out_ready4;

  logic [11:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [1:0]  mode3, fsel3, out_sel3;
  logic [3:0]  out_data3;
  logic        out_valid3, out_ready3;

  int total = 0;
  int bad   = 0;

  mux_arb_nxw #(.WIDTH(4), .CHANNELS(4)) dut4 (
    .clk(clk), .reset_L(reset_L), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .mode(mode4), .force_sel(fsel4), .out_data(out_data4),
    .out_sel(out_sel4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  mux_arb_nxw #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk(clk), .reset_L(reset_L), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .force_sel(fsel3), .out_data(out_data3),
    .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  // Reference model state, index 0 = 4-lane instance, 1 = 3-lane instance.
  logic       mv[2];
  logic [3:0] md[2];
  int         ms[2];
  int         mp[2];

  function automatic int pick(int nch, logic [3:0] v, logic [1:0] m, int fs, int p);
    if (m == 2'b00) return (fs < nch && v[fs]) ? fs : -1;
    for (int i = 0; i < nch; i++) begin
      int k;
      k = (m == 2'b01) ? i : (p + i) % nch;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int id, int nch, logic [3:0] v, logic [1:0] m,
                                           int fs, logic ordy);
    int g;
    if (mv[id] && !ordy) return 4'b0;
    g = pick(nch, v, m, fs, mp[id]);
    return (g < 0) ? 4'b0 : (4'b1 << g);
  endfunction

  function automatic void step_model(int id, int nch, logic [3:0] v, logic [1:0] m, int fs,
                                     logic ordy, logic [15:0] d);
    int g;
    if (mv[id] && !ordy) return;
    g = pick(nch, v, m, fs, mp[id]);
    if (g < 0) begin
      mv[id] = 1'b0;
    end else begin
      mv[id] = 1'b1;
      md[id] = d[g*4 +: 4];
      ms[id] = g;
      if (m[1]) mp[id] = (g + 1) % nch;
    end
  endfunction

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 2; i++) begin
        mv[i] = 1'b0; md[i] = 4'h0; ms[i] = 0; mp[i] = 0;
      end
    end else begin
      step_model(0, 4, in_valid4, mode4, int'(fsel4), out_ready4, in_data4);
      step_model(1, 3, {1'b0, in_valid3}, mode3, int'(fsel3), out_ready3, {4'h0, in_data3});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_data4 = '0; in_valid4 = '0; mode4 = 2'b10; fsel4 = '0; out_ready4 = 1'b1;
    in_data3 = '0; in_valid3 = '0; mode3 = 2'b10; fsel3 = '0; out_ready3 = 1'b1;
    reset_L = 1'b1;
    #1 reset_L = 1'b0;
    repeat (2) tick();
    reset_L = 1'b1;
    tick();
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid4); end
    total++; if (out_data4 !== 4'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data4); end
    total++; if (out_sel4 !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", out_sel4); end
    total++; if (dut4.rr_ptr !== 2'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", dut4.rr_ptr); end
    total++; if (in_ready4 !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", in_ready4); end
    total++; if (out_valid3 !== 1'b0) begin bad++; $display("FAIL reset_valid3 got=%b exp=0", out_valid3); end
  endtask

  task automatic test_rr_fair();
    mode4 = 2'b10; in_valid4 = 4'hF; in_data4 = {4'hD, 4'hC, 4'hB, 4'hA}; out_ready4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (in_ready4 !== (4'b1 << (k % 4))) begin
        bad++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", k, in_ready4, 4'b1 << (k % 4));
      end
      tick();
      total++;
      if (out_valid4 !== 1'b1 || out_sel4 !== 2'(k % 4) || out_data4 !== 4'(4'hA + k % 4)) begin
        bad++; $display("FAIL rr_seq cyc=%0d got v=%b sel=%0d d=%h exp v=1 sel=%0d d=%h",
                        k, out_valid4, out_sel4, out_data4, k % 4, 4'hA + k % 4);
      end
    end
  endtask

  task automatic test_fixed();
    mode4 = 2'b01; in_valid4 = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (in_ready4 !== 4'b0010) begin bad++; $display("FAIL fixed_ready got=%b exp=0010", in_ready4); end
      tick();
      total++; if (out_sel4 !== 2'd1 || out_data4 !== 4'hB) begin
        bad++; $display("FAIL fixed_sel got=%0d/%h exp=1/b", out_sel4, out_data4);
      end
    end
    in_valid4 = 4'b1000;
    #1;
    total++; if (in_ready4 !== 4'b1000) begin bad++; $display("FAIL fixed_drop_ready got=%b exp=1000", in_ready4); end
    tick();
    total++; if (out_sel4 !== 2'd3 || out_data4 !== 4'hD) begin
      bad++; $display("FAIL fixed_drop_sel got=%0d/%h exp=3/d", out_sel4, out_data4);
    end
  endtask

  task automatic test_forced();
    mode4 = 2'b00; fsel4 = 2'd2; in_valid4 = 4'hF;
    #1;
    total++; if (in_ready4 !== 4'b0100) begin bad++; $display("FAIL forced_ready got=%b exp=0100", in_ready4); end
    tick();
    total++; if (out_valid4 !== 1'b1 || out_sel4 !== 2'd2 || out_data4 !== 4'hC) begin
      bad++; $display("FAIL forced_sel got=%b/%0d/%h exp=1/2/c", out_valid4, out_sel4, out_data4);
    end
    in_valid4 = 4'b1011;
    #1;
    total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL forced_idle_ready got=%b exp=0000", in_ready4); end
    tick();
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL forced_idle_valid got=%b exp=0", out_valid4); end
  endtask

  task automatic test_backpressure();
    int held_sel, held_ptr;
    logic [3:0] held_data;
    mode4 = 2'b10; in_valid4 = 4'hF; out_ready4 = 1'b1;
    tick();
    held_sel = ms[0]; held_data = md[0]; held_ptr = mp[0];
    total++; if (out_valid4 !== 1'b1 || out_sel4 !== 2'(held_sel)) begin
      bad++; $display("FAIL bp_load got=%b/%0d exp=1/%0d", out_valid4, out_sel4, held_sel);
    end
    out_ready4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (in_ready4 !== 4'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", k, in_ready4); end
      tick();
      total++;
      if (out_valid4 !== 1'b1 || out_sel4 !== 2'(held_sel) || out_data4 !== held_data
          || dut4.rr_ptr !== 2'(held_ptr)) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%h ptr=%0d exp=1/%0d/%h ptr=%0d", k,
                        out_valid4, out_sel4, out_data4, dut4.rr_ptr, held_sel, held_data, held_ptr);
      end
    end
    out_ready4 = 1'b1;
    tick();
    total++; if (out_sel4 !== 2'((held_sel + 1) % 4)) begin
      bad++; $display("FAIL bp_release got=%0d exp=%0d", out_sel4, (held_sel + 1) % 4);
    end
  endtask

  task automatic test_reset_mid();
    mode4 = 2'b10; in_valid4 = 4'hF; out_ready4 = 1'b1;
    repeat (2) tick();
    total++; if (out_valid4 !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid4); end
    #2 reset_L = 1'b0;
    #1;
    total++;
    if (out_valid4 !== 1'b0 || out_data4 !== 4'h0 || out_sel4 !== 2'd0 || dut4.rr_ptr !== 2'd0) begin
      bad++; $display("FAIL mid_reset got=%b/%h/%0d ptr=%0d exp=0/0/0 ptr=0",
                      out_valid4, out_data4, out_sel4, dut4.rr_ptr);
    end
    in_valid4 = 4'h0;
    tick();
    reset_L = 1'b1;
    tick();
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL mid_no_replay got=%b exp=0", out_valid4); end
  endtask

  task automatic test_np2();
    mode3 = 2'b10; in_valid3 = 3'b111; in_data3 = {4'hC, 4'hB, 4'hA}; out_ready3 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (out_sel3 !== 2'(k % 3) || out_data3 !== 4'(4'hA + k % 3) || dut3.rr_ptr !== 2'((k + 1) % 3)) begin
        bad++; $display("FAIL np2_rr cyc=%0d got sel=%0d d=%h ptr=%0d exp sel=%0d d=%h ptr=%0d", k,
                        out_sel3, out_data3, dut3.rr_ptr, k % 3, 4'hA + k % 3, (k + 1) % 3);
      end
    end
    mode3 = 2'b01;
    tick();
    total++; if (out_sel3 !== 2'd0 || dut3.rr_ptr !== 2'd2) begin
      bad++; $display("FAIL np2_mode_switch got sel=%0d ptr=%0d exp sel=0 ptr=2", out_sel3, dut3.rr_ptr);
    end
    mode3 = 2'b00; fsel3 = 2'd3;
    #1;
    total++; if (in_ready3 !== 3'b000) begin bad++; $display("FAIL np2_force_oob got=%b exp=000", in_ready3); end
    tick();
    total++; if (out_valid3 !== 1'b0) begin bad++; $display("FAIL np2_force_oob_valid got=%b exp=0", out_valid3); end
  endtask

  task automatic test_random();
    logic [3:0] er4, er3;
    for (int k = 0; k < 400; k++) begin
      mode4 = 2'($urandom_range(0, 3)); fsel4 = 2'($urandom_range(0, 3));
      in_valid4 = 4'($urandom); in_data4 = 16'($urandom);
      out_ready4 = ($urandom_range(0, 3) != 0);
      mode3 = 2'($urandom_range(0, 3)); fsel3 = 2'($urandom_range(0, 3));
      in_valid3 = 3'($urandom); in_data3 = 12'($urandom);
      out_ready3 = ($urandom_range(0, 3) != 0);
      #1;
      er4 = exp_ready(0, 4, in_valid4, mode4, int'(fsel4), out_ready4);
      er3 = exp_ready(1, 3, {1'b0, in_valid3}, mode3, int'(fsel3), out_ready3);
      total++; if (in_ready4 !== er4) begin bad++; $display("FAIL rand_ready4 cyc=%0d got=%b exp=%b", k, in_ready4, er4); end
      total++; if (in_ready3 !== er3[2:0]) begin bad++; $display("FAIL rand_ready3 cyc=%0d got=%b exp=%b", k, in_ready3, er3[2:0]); end
      tick();
      total++;
      if (out_valid4 !== mv[0] || (mv[0] && (out_sel4 !== 2'(ms[0]) || out_data4 !== md[0]))
          || dut4.rr_ptr !== 2'(mp[0])) begin
        bad++; $display("FAIL rand_out4 cyc=%0d got=%b/%0d/%h ptr=%0d exp=%b/%0d/%h ptr=%0d", k,
                        out_valid4, out_sel4, out_data4, dut4.rr_ptr, mv[0], ms[0], md[0], mp[0]);
      end
      total++;
      if (out_valid3 !== mv[1] || (mv[1] && (out_sel3 !== 2'(ms[1]) || out_data3 !== md[1]))
          || dut3.rr_ptr !== 2'(mp[1])) begin
        bad++; $display("FAIL rand_out3 cyc=%0d got=%b/%0d/%h ptr=%0d exp=%b/%0d/%h ptr=%0d", k,
                        out_valid3, out_sel3, out_data3, dut3.rr_ptr, mv[1], ms[1], md[1], mp[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_fair();
    test_fixed();
    test_forced();
    test_backpressure();
    test_reset_mid();
    test_np2();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
